data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory for a pipelined core.
// Accepts one load/store at a time, holds it for LATENCY cycles, then
// presents a response until the pipeline consumes it. The accept cycle
// is cycle 0, and rsp_valid is first high in cycle LATENCY.
// Backing store is a little-endian byte array that is not reset.
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword and word accesses are flagged on rsp_err and suppressed.
// Otherwise they are aligned down and performed normally.
module data_mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 17,
  parameter int LATENCY        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {ACC_BYTE, ACC_HALF, ACC_WORD} acc_t;

  localparam bit         LAT_ONE  = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                    state;
  logic [3:0]                cnt;

  logic                      we_p0;
  logic [2:0]                size_p0;
  logic [MEM_ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0]     wdata_p0;

  logic [7:0]                mem [0:(2**MEM_ADDR_WIDTH)-1];

  logic                      cur_we;
  logic [2:0]                cur_size;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]     cur_wdata;
  acc_t                      acc;
  logic [MEM_ADDR_WIDTH-1:0] base;
  logic                      mis;
  logic                      enter_resp;
  logic                      do_store;
  logic [DATA_WIDTH-1:0]     rsp_data_next;
  logic [7:0]                rd0, rd1, rd2, rd3;
  logic                      unused_addr_hi;

  // Store codes 100/101 are SW, while the same codes on a load are LBU/LHU.
  function automatic acc_t access_width(input logic we, input logic [2:0] size);
    acc_t a;
    case (size)
      3'b000:  a = ACC_BYTE;
      3'b001:  a = ACC_HALF;
      3'b100:  a = we ? ACC_WORD : ACC_BYTE;
      3'b101:  a = we ? ACC_WORD : ACC_HALF;
      default: a = ACC_WORD;
    endcase
    return a;
  endfunction

  // Load extension. Unlisted codes (011, 110, 111) read as a full word.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [2:0] size,
    input logic [7:0] b0, input logic [7:0] b1,
    input logic [7:0] b2, input logic [7:0] b3
  );
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [DATA_WIDTH-1:0] r;
    sb = $signed(b0);
    sh = $signed({b1, b0});
    case (size)
      3'b000:  r = DATA_WIDTH'(sb);
      3'b001:  r = DATA_WIDTH'(sh);
      3'b100:  r = DATA_WIDTH'(b0);
      3'b101:  r = DATA_WIDTH'({b1, b0});
      default: r = DATA_WIDTH'({b3, b2, b1, b0});
    endcase
    return r;
  endfunction

  // Address bits above the decoded window simply wrap.
  assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:MEM_ADDR_WIDTH];

  // With LATENCY == 1 the response is formed straight from the request
  // inputs, so the access fields come from the ports while IDLE.
  assign cur_we    = (state == IDLE) ? req_we    : we_p0;
  assign cur_size  = (state == IDLE) ? req_size  : size_p0;
  assign cur_addr  = (state == IDLE) ? req_addr[MEM_ADDR_WIDTH-1:0] : addr_p0;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_p0;
  assign acc       = access_width(cur_we, cur_size);

  // The access is aligned down to its natural boundary.
  always_comb begin
    base = cur_addr;
    if (acc == ACC_HALF) base[0]   = 1'b0;
    if (acc == ACC_WORD) base[1:0] = 2'b00;
  end

`ifdef MISALIGN_TRAP_EN
  assign mis = ((acc == ACC_HALF) && cur_addr[0]) ||
               ((acc == ACC_WORD) && (cur_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign enter_resp = (state == IDLE && req_valid && LAT_ONE) ||
                      (state == WAIT && cnt == 4'd0);
  assign do_store   = rst && enter_resp && cur_we && !mis;

  assign rd0 = mem[base];
  assign rd1 = mem[base + MEM_ADDR_WIDTH'(1)];
  assign rd2 = mem[base + MEM_ADDR_WIDTH'(2)];
  assign rd3 = mem[base + MEM_ADDR_WIDTH'(3)];

  // Stores and trapped accesses return zero data.
  always_comb begin
    rsp_data_next = '0;
    if (!cur_we && !mis) rsp_data_next = load_extend(cur_size, rd0, rd1, rd2, rd3);
  end

  // Capture the accepted request. Later port activity is ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      addr_p0  <= req_addr[MEM_ADDR_WIDTH-1:0];
      wdata_p0 <= req_wdata;
    end
  end

  // Commit stores on the edge entering RESP, writing only the addressed bytes.
  always_ff @(posedge clk) begin
    if (do_store) begin
      mem[base] <= cur_wdata[7:0];
      if (acc != ACC_BYTE) mem[base + MEM_ADDR_WIDTH'(1)] <= cur_wdata[15:8];
      if (acc == ACC_WORD) begin
        mem[base + MEM_ADDR_WIDTH'(2)] <= cur_wdata[23:16];
        mem[base + MEM_ADDR_WIDTH'(3)] <= cur_wdata[31:24];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            busy      <= 1'b1;
            req_ready <= 1'b0;
            if (LAT_ONE) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_data_next;
              rsp_err   <= mis;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_data_next;
            rsp_err   <= mis;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
